// File: rtl/dmem_block_responder_if.sv
// Cache-side handshake bundle for dmem_block_responder: request, address and store data
// from the cache controller; ready pulse, filled block and busy back from memory.
interface dmem_block_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W-1:0]     word_address;
    logic [DATA_W-1:0]     data_in;
    logic                  ready;
    logic [4*DATA_W-1:0]   block_out;
    logic                  busy;

    modport master (
        output mem_read, mem_write, word_address, data_in,
        input  ready, block_out, busy
    );

    modport slave (
        input  mem_read, mem_write, word_address, data_in,
        output ready, block_out, busy
    );
endinterface

// File: rtl/dmem_block_responder.sv
// Data-memory responder: 4-word block fills and single-word stores after LATENCY cycles.
// Optional macro DMEM_FAST_WRITE_EN makes stores complete one cycle after acceptance.
module dmem_block_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_block_responder_if.slave dmem
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BLK_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] RdLoad = CNT_W'(LATENCY - 1);
`ifdef DMEM_FAST_WRITE_EN
    localparam logic [CNT_W-1:0] WrLoad = '0;
`else
    localparam logic [CNT_W-1:0] WrLoad = CNT_W'(LATENCY - 1);
`endif

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_t;

    state_t              r_state, w_state_d;
    logic [CNT_W-1:0]    r_count, w_count_d;
    logic [BLK_W-1:0]    r_blk_addr, w_blk_addr_d;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_d;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_d;
    logic                r_ready, w_ready_d;
    logic                r_busy, w_busy_d;
    logic [4*DATA_W-1:0] r_block, w_block_d;
    logic                w_mem_we;
    logic [4*DATA_W-1:0] w_rd_block;

    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    assign w_rd_block = {r_mem[{r_blk_addr, 2'd3}], r_mem[{r_blk_addr, 2'd2}],
                         r_mem[{r_blk_addr, 2'd1}], r_mem[{r_blk_addr, 2'd0}]};

    always_comb begin
        w_state_d    = r_state;
        w_count_d    = r_count;
        w_blk_addr_d = r_blk_addr;
        w_wr_addr_d  = r_wr_addr;
        w_wr_data_d  = r_wr_data;
        w_ready_d    = 1'b0;
        w_busy_d     = r_busy;
        w_block_d    = r_block;
        w_mem_we     = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Read has priority; a simultaneous write is dropped, not queued.
                if (dmem.mem_read) begin
                    w_blk_addr_d = dmem.word_address[ADDR_W-1:2];
                    w_count_d    = RdLoad;
                    w_busy_d     = 1'b1;
                    w_state_d    = StRdWait;
                end else if (dmem.mem_write) begin
                    w_wr_addr_d = dmem.word_address;
                    w_wr_data_d = dmem.data_in;
                    w_count_d   = WrLoad;
                    w_busy_d    = 1'b1;
                    w_state_d   = StWrWait;
                end
            end
            StRdWait: begin
                if (r_count != '0) begin
                    w_count_d = r_count - 1'b1;
                end else begin
                    w_block_d = w_rd_block;
                    w_ready_d = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = StIdle;
                end
            end
            StWrWait: begin
                if (r_count != '0) begin
                    w_count_d = r_count - 1'b1;
                end else begin
                    w_mem_we  = 1'b1;
                    w_ready_d = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_blk_addr <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_block    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_count    <= w_count_d;
            r_blk_addr <= w_blk_addr_d;
            r_wr_addr  <= w_wr_addr_d;
            r_wr_data  <= w_wr_data_d;
            r_ready    <= w_ready_d;
            r_busy     <= w_busy_d;
            r_block    <= w_block_d;
        end
    end

    // Array is never cleared; reset only suppresses a commit that lands on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

    assign dmem.ready     = r_ready;
    assign dmem.busy      = r_busy;
    assign dmem.block_out = r_block;
endmodule

// File: tb/tb_dmem_block_responder.sv
// Bench for dmem_block_responder: timed transaction model checked every cycle, plus
// directed scenarios with literal expectations. Honours DMEM_FAST_WRITE_EN.
module tb_dmem_block_responder;
    localparam int LAT = 4;
`ifdef DMEM_FAST_WRITE_EN
    localparam int WR_LAT = 1;
`else
    localparam int WR_LAT = LAT;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_block_responder_if bus   ();
    dmem_block_responder_if bus1  ();
    dmem_block_responder_if bus15 ();

    dmem_block_responder #(.LATENCY(LAT)) u_dut   (.clk(clk), .rst(rst), .dmem(bus));
    dmem_block_responder #(.LATENCY(1))   u_lat1  (.clk(clk), .rst(rst), .dmem(bus1));
    dmem_block_responder #(.LATENCY(15))  u_lat15 (.clk(clk), .rst(rst), .dmem(bus15));

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: each accepted request finishes a fixed number of edges later.
    logic [31:0]  m_mem   [1024];
    bit           m_known [1024];
    bit           started = 1'b0;
    bit           pend = 1'b0;
    bit           pend_rd;
    int           edge_no = 0;
    int           done_at;
    logic [9:0]   pend_addr;
    logic [31:0]  pend_data;
    logic         e_ready, e_busy;
    logic [127:0] e_block, e_mask;

    always @(posedge clk) begin
        edge_no++;
        if (rst) begin
            started = 1'b1;
            pend    = 1'b0;
            e_ready = 1'b0;
            e_busy  = 1'b0;
            e_block = '0;
            e_mask  = '1;
        end else if (started) begin
            e_ready = 1'b0;
            if (pend) begin
                if (edge_no == done_at) begin
                    if (pend_rd) begin
                        for (int w = 0; w < 4; w++) begin
                            logic [9:0] idx;
                            idx = {pend_addr[9:2], 2'(w)};
                            e_block[32*w +: 32] = m_mem[idx];
                            e_mask[32*w +: 32]  = m_known[idx] ? 32'hFFFF_FFFF : 32'h0;
                        end
                    end else begin
                        m_mem[pend_addr]   = pend_data;
                        m_known[pend_addr] = 1'b1;
                    end
                    pend    = 1'b0;
                    e_ready = 1'b1;
                end
            end else if (bus.mem_read) begin
                pend = 1'b1; pend_rd = 1'b1; pend_addr = bus.word_address;
                done_at = edge_no + LAT;
            end else if (bus.mem_write) begin
                pend = 1'b1; pend_rd = 1'b0; pend_addr = bus.word_address;
                pend_data = bus.data_in;
                done_at = edge_no + WR_LAT;
            end
            e_busy = pend;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_ready", bus.ready, e_ready);
            check("cyc_busy", bus.busy, e_busy);
            check("cyc_block", bus.block_out & e_mask, e_block & e_mask);
        end
    end

    // Starts and ends 1 time unit after a rising edge; holds the request until ready.
    task automatic xact(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input int exp_lat, input string nm);
        int cnt = 0;
        bus.mem_read = rd; bus.mem_write = wr; bus.word_address = a; bus.data_in = d;
        @(posedge clk); #1;
        while (bus.ready !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        check({nm, "_lat"}, 128'(cnt), 128'(exp_lat));
    endtask

    task automatic probe(input int which, input int exp_lat);
        int   first = -1;
        int   nready = 0;
        int   nbusy = 0;
        logic r, b;
        if (which == 1) begin bus1.mem_read = 1'b1; bus1.word_address = 10'h0A0; end
        else begin bus15.mem_read = 1'b1; bus15.word_address = 10'h0A0; end
        @(posedge clk); #1;
        bus1.mem_read = 1'b0; bus15.mem_read = 1'b0;
        for (int i = 0; i < 20; i++) begin
            r = (which == 1) ? bus1.ready : bus15.ready;
            b = (which == 1) ? bus1.busy : bus15.busy;
            if (b) nbusy++;
            if (r) begin
                nready++;
                if (first < 0) first = i;
            end
            @(posedge clk); #1;
        end
        check($sformatf("lat%0d_edge", which), 128'(first), 128'(exp_lat));
        check($sformatf("lat%0d_width", which), 128'(nready), 128'd1);
        check($sformatf("lat%0d_busy", which), 128'(nbusy), 128'(exp_lat));
    endtask

    initial begin
        int rdy_seen;
        int p0, p1, np;
        logic [127:0] held_blk;
        bus.mem_read = 0; bus.mem_write = 0; bus.word_address = '0; bus.data_in = '0;
        bus1.mem_read = 0; bus1.mem_write = 0; bus1.word_address = '0; bus1.data_in = '0;
        bus15.mem_read = 0; bus15.mem_write = 0; bus15.word_address = '0; bus15.data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", bus.ready, 128'd0);
        check("rst_busy", bus.busy, 128'd0);
        check("rst_block", bus.block_out, 128'd0);

        // Reset abort of an in-flight write
        xact(0, 1, 10'h010, 32'h1234_5678, WR_LAT, "pre_wr");
        bus.mem_write = 1'b1; bus.word_address = 10'h010; bus.data_in = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.mem_write = 1'b0;
        rst = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst = 1'b0;
            if (bus.ready) rdy_seen++;
        end
        check("abort_no_ready", 128'(rdy_seen), 128'd0);
        check("abort_ready", bus.ready, 128'd0);
        check("abort_busy", bus.busy, 128'd0);
        check("abort_block", bus.block_out, 128'd0);
        xact(1, 0, 10'h010, 32'h0, LAT, "abort_rd");
        check("abort_word0", bus.block_out[31:0], 128'h1234_5678);
        check("abort_not_dead", 128'(bus.block_out[31:0] == 32'hDEAD_BEEF), 128'd0);

        // Basic write then block read
        for (int i = 0; i < 4; i++)
            xact(0, 1, 10'h0A0 + 10'(i), 32'h1111_1111 * (i + 1), WR_LAT, "basic_wr");
        xact(1, 0, 10'h0A2, 32'h0, LAT, "basic_rd");
        check("basic_block", bus.block_out, 128'h44444444_33333333_22222222_11111111);

        probe(1, 1);
        probe(15, 15);

        // Simultaneous read+write: read wins, store dropped
        xact(0, 1, 10'h3FC, 32'h0BAD_C0DE, WR_LAT, "old_wr");
        xact(1, 1, 10'h3FC, 32'hCAFE_F00D, LAT, "both");
        xact(1, 0, 10'h3FC, 32'h0, LAT, "both_rd");
        check("both_old_word", bus.block_out[31:0], 128'h0BAD_C0DE);

        // Held read: re-accepted after each ready; address change mid-wait ignored
        bus.mem_read = 1'b1; bus.word_address = 10'h0A0;
        p0 = -1; p1 = -1; np = 0; held_blk = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.word_address = 10'h3FC;
            if (bus.ready) begin
                np++;
                if (p0 < 0) begin p0 = i; held_blk = bus.block_out; end
                else if (p1 < 0) p1 = i;
            end
        end
        bus.mem_read = 1'b0;
        check("held_pulses", 128'(np), 128'd2);
        check("held_spacing", 128'(p1 - p0), 128'd5);
        check("held_block", held_blk, 128'h44444444_33333333_22222222_11111111);
        repeat (6) begin @(posedge clk); #1; end

        // Write followed immediately by a read of the same block
        xact(0, 1, 10'h155, 32'h5A5A_5A5A, WR_LAT, "fast_wr");
        xact(1, 0, 10'h154, 32'h0, LAT, "fast_rd");
        check("fast_word1", bus.block_out[63:32], 128'h5A5A_5A5A);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/dmem_block_responder.md
Name: dmem_block_responder

Overview:
- Data-memory side of the cache/Dmem handshake. Answers the data cache's miss fills and write-through stores.
- On a read, returns a whole 4-word block after a fixed latency.
- On a write, commits a single word after the same latency.
- Signals completion of either operation with a one-cycle `ready` pulse.

Parameters:
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, word width
- LATENCY, 4, cycles from request acceptance to `ready`; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; synchronous, active-high
- mem_read  input  1  block-fill request from the cache controller
- mem_write  input  1  word-store request from the cache controller
- word_address  input  10  word address; [9:2] selects the block, [1:0] is the word offset
- data_in  input  32  store data, used when mem_write=1
- ready  output  1  one-cycle completion pulse for the current read or write
- block_out  output  128  filled block; word0 in [31:0] through word3 in [127:96]; valid when ready=1 after a read
- busy  output  1  high while a request is in flight

Behaviour:
- Storage: 1024 x 32 array. Array contents are not cleared by reset.
- Reset (rst=1 at a rising edge):
  - state=IDLE, counter=0, ready=0, busy=0, block_out=0.
  - An in-flight write is aborted and not committed.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE:
  - Requests are sampled at the rising edge.
  - mem_read=1: latch word_address[9:2], counter<=LATENCY-1, go to RD_WAIT, busy<=1.
  - mem_write=1 with mem_read=0: latch the full address and data_in, counter<=LATENCY-1, go to WR_WAIT, busy<=1.
  - Both high at once: read wins; the write is not latched.
  - Neither high: stay in IDLE; ready=0.
- RD_WAIT / WR_WAIT:
  - While counter!=0: decrement counter by 1 per cycle. Request inputs are ignored; latched values are used.
  - When counter==0 in RD_WAIT: at this edge, block_out<=the 4 words of the latched block, ready<=1, busy<=0, go to IDLE.
  - When counter==0 in WR_WAIT: at this edge, array[latched addr]<=latched data, ready<=1, busy<=0, go to IDLE.
- Timing:
  - Accepted at edge k means ready is high for exactly the cycle following edge k+LATENCY.
  - Minimum request-to-request spacing is LATENCY+1 cycles.
- ready:
  - Registered; never high for two consecutive cycles.
  - Deasserts at the edge after it rises, even if a new request is accepted at that same edge.
- Back-to-back requests:
  - A request still high in the IDLE cycle after ready is accepted as a new request.
  - The requester must drop its request in the ready cycle to avoid a repeat.
- block_out holds its last value until the next read completes. Writes do not change block_out.
- Read after write to the same block: the read returns the newly written word, because the write committed at its ready edge.
- rst during RD_WAIT or WR_WAIT: behaves as the reset above; no ready pulse is issued for the aborted request.

Optional Feature:
- Macro: DMEM_FAST_WRITE_EN.
- Defined: writes ignore LATENCY.
  - mem_write accepted in IDLE commits the word at edge k+1 and ready is high for the cycle after edge k+1.
  - busy is high for one cycle.
  - Reads keep the full LATENCY.
- Undefined: writes use LATENCY exactly as reads do.

Test Plan:
- Reset abort: rst=1 for 2 cycles mid-WR_WAIT (write addr 0x010, data 0xDEADBEEF) -> ready never pulses; ready=0, busy=0, block_out=0 after reset; a later read of block 0x04 does not return 0xDEADBEEF.
- Basic write/read:
  - Stimulus: LATENCY=4; write 0x11111111..0x44444444 to addr 0x0A0..0x0A3, each held until ready; then mem_read at addr 0x0A2.
  - Required: ready rises exactly 4 edges after each acceptance; block_out=0x44444444_33333333_22222222_11111111 with ready=1.
- Latency and pulse width: LATENCY=1 and LATENCY=15 with a single read each -> ready is high for exactly 1 cycle, at edge k+1 and edge k+15 respectively; busy is high for exactly LATENCY cycles.
- Simultaneous request: mem_read=1 and mem_write=1 in IDLE at addr 0x3FC, data 0xCAFEF00D -> read serviced; a subsequent read of 0x3FC shows the old word, not 0xCAFEF00D.
- Held request: mem_read held high for 12 cycles, LATENCY=4 -> two ready pulses, 5 cycles apart; inputs changed mid-wait do not affect the returned block.
- DMEM_FAST_WRITE_EN defined: write to 0x155 -> ready the cycle after edge k+1; an immediate read of block 0x55 returns the new word, with ready at edge +4.
